// File: rtl/tiny_soc_mmio_responder.sv
// MMIO responder for a tiny SoC: STOP/exit-code latch, TX byte FIFO, cycle counter,
// scratch register and status word, answering each granted request one cycle later.
module tiny_soc_mmio_responder #(
  parameter int unsigned MMIOAddrWidth = 31,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned StrbWidth     = DataWidth / 8,
  parameter int unsigned TxDepth       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mmio_req_i,
  input  logic                     mmio_we_i,
  input  logic [MMIOAddrWidth-1:0] mmio_addr_i,
  input  logic [StrbWidth-1:0]     mmio_strb_i,
  input  logic [DataWidth-1:0]     mmio_wdata_i,
  output logic                     mmio_gnt_o,
  output logic                     mmio_rvalid_o,
  output logic [DataWidth-1:0]     mmio_rdata_o,
  output logic                     mmio_err_o,
  output logic                     stop_o,
  output logic [31:0]              exit_code_o,
  output logic                     tx_valid_o,
  output logic [7:0]               tx_data_o,
  input  logic                     tx_ready_i
);

  localparam int unsigned PtrW = $clog2(TxDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [4:0] {
    REG_STOP    = 5'd0,
    REG_TXDATA  = 5'd1,
    REG_MCYCLE  = 5'd2,
    REG_SCRATCH = 5'd3,
    REG_STATUS  = 5'd4
  } reg_e;

  logic [DataWidth-1:0] mcycle_q;
  logic [DataWidth-1:0] scratch_q;
  logic                 stop_q;
  logic [31:0]          exit_q;
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] rdata_d;
  logic                 err_q;
  logic [7:0]           fifo_q [TxDepth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic [4:0] reg_idx;
  logic       addr_hi_zero;
  logic       acc_ok;
  logic       tx_push_req;
  logic       fifo_full;
  logic       fifo_empty;
  logic       gnt;
  logic       push;
  logic       pop;
  logic       unused_addr_lsb;

  assign reg_idx         = mmio_addr_i[7:3];
  assign addr_hi_zero    = (mmio_addr_i[MMIOAddrWidth-1:8] == '0);
  assign unused_addr_lsb = ^mmio_addr_i[2:0];

  // acc_ok folds decode and direction legality; anything else is an error response
  always_comb begin
    acc_ok = 1'b0;
    if (addr_hi_zero) begin
      case (reg_idx)
        REG_STOP, REG_TXDATA:   acc_ok = mmio_we_i;
        REG_MCYCLE, REG_STATUS: acc_ok = ~mmio_we_i;
        REG_SCRATCH:            acc_ok = 1'b1;
        default:                acc_ok = 1'b0;
      endcase
    end
  end

  assign fifo_full   = (count_q == CntW'(TxDepth));
  assign fifo_empty  = (count_q == '0);
  assign tx_push_req = mmio_req_i & mmio_we_i & acc_ok & (reg_idx == REG_TXDATA) & mmio_strb_i[0];
  assign gnt         = rst_ni & mmio_req_i & ~(tx_push_req & fifo_full);
  assign push        = gnt & tx_push_req;
  assign pop         = tx_valid_o & tx_ready_i;

  always_comb begin
    rdata_d = '0;
    if (acc_ok && !mmio_we_i) begin
      case (reg_idx)
        REG_MCYCLE:  rdata_d = mcycle_q;
        REG_SCRATCH: rdata_d = scratch_q;
        REG_STATUS: begin
          rdata_d[0]    = stop_q;
          rdata_d[1]    = fifo_full;
          rdata_d[2]    = fifo_empty;
          rdata_d[15:8] = 8'(count_q);
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcycle_q  <= '0;
      scratch_q <= '0;
      stop_q    <= 1'b0;
      exit_q    <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int unsigned i = 0; i < TxDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      mcycle_q <= mcycle_q + DataWidth'(1);
      rvalid_q <= gnt;
      rdata_q  <= gnt ? rdata_d : '0;
      err_q    <= gnt & ~acc_ok;

      if (gnt && mmio_we_i && acc_ok) begin
        if ((reg_idx == REG_STOP) && (mmio_strb_i[3:0] != '0) && !stop_q) begin
          stop_q <= 1'b1;
          exit_q <= mmio_wdata_i[31:0];
        end
        if (reg_idx == REG_SCRATCH) begin
          for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (mmio_strb_i[b]) begin
              scratch_q[8*b +: 8] <= mmio_wdata_i[8*b +: 8];
            end
          end
        end
      end

      if (push) begin
        fifo_q[wr_ptr_q] <= mmio_wdata_i[7:0];
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign mmio_gnt_o    = gnt;
  assign mmio_rvalid_o = rvalid_q;
  assign mmio_rdata_o  = rdata_q;
  assign mmio_err_o    = err_q;
  assign stop_o        = stop_q;
  assign exit_code_o   = exit_q;
  assign tx_valid_o    = ~fifo_empty;
  assign tx_data_o     = tx_valid_o ? fifo_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_tiny_soc_mmio_responder.sv
// Randomised self-checking bench for tiny_soc_mmio_responder against a register/queue model.
module tb_tiny_soc_mmio_responder;

  localparam int DEPTH = 4;
  localparam logic [30:0] A_STOP = 31'h00, A_TX = 31'h08, A_MC = 31'h10,
                          A_SC = 31'h18, A_ST = 31'h20;

  logic        clk;
  logic        rst_n;
  logic        req, we, gnt, rvalid, err, stop, tx_valid, tx_ready;
  logic [30:0] addr;
  logic [7:0]  strb, tx_data;
  logic [63:0] wdata, rdata;
  logic [31:0] exit_code;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          ready_mode = 0;
  int          fifo_cnt_cur = 0;
  int          g_cnt = 0;
  logic [7:0]  q[$];
  bit          m_stop = 0;
  logic [31:0] m_exit = '0;
  logic [63:0] m_scratch = '0;
  time         t_rel = 0;

  tiny_soc_mmio_responder #(
    .MMIOAddrWidth(31), .DataWidth(64), .StrbWidth(8), .TxDepth(DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mmio_req_i(req), .mmio_we_i(we),
    .mmio_addr_i(addr), .mmio_strb_i(strb), .mmio_wdata_i(wdata),
    .mmio_gnt_o(gnt), .mmio_rvalid_o(rvalid), .mmio_rdata_o(rdata),
    .mmio_err_o(err), .stop_o(stop), .exit_code_o(exit_code),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int reg_of(input logic [30:0] a);
    if ((a >> 8) != 0) return -1;
    if (a[7:3] > 5'd4) return -1;
    return int'(a[7:3]);
  endfunction

  function automatic bit access_ok(input bit w, input logic [30:0] a);
    int r = reg_of(a);
    if (r < 0) return 1'b0;
    return w ? (r == 0 || r == 1 || r == 3) : (r == 2 || r == 3 || r == 4);
  endfunction

  function automatic bit is_push(input bit w, input logic [30:0] a, input logic [7:0] s);
    return w && reg_of(a) == 1 && s[0];
  endfunction

  // Counter value during the cycle ending at edge g: edges seen since release.
  function automatic logic [63:0] mcyc_at(input time g);
    return 64'((g - t_rel - 8) / 10);
  endfunction

  function automatic logic [63:0] status_word(input int cnt);
    logic [63:0] w = '0;
    w[0] = m_stop;
    w[1] = (cnt == DEPTH);
    w[2] = (cnt == 0);
    w[15:8] = 8'(cnt);
    return w;
  endfunction

  // Advance one cycle; drive tx_ready at +1, check the TX head against the model at +2.
  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin tx_ready = 1'b1; ready_mode = 3; end
      3: begin tx_ready = 1'b0; ready_mode = 0; end
      default: tx_ready = 1'b0;
    endcase
    #1;
    if (rst_n) begin
      fifo_cnt_cur = q.size();
      n_checks++;
      if (tx_valid !== (q.size() != 0)) begin
        n_fails++;
        $display("FAIL tx_valid: got %b expected %b", tx_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_checks++;
        if (tx_data !== q[0]) begin
          n_fails++;
          $display("FAIL tx_data: got %h expected %h", tx_data, q[0]);
        end
        if (tx_ready) void'(q.pop_front());
      end
    end
  endtask

  task automatic do_req(input bit w, input logic [30:0] a, input logic [7:0] s,
                        input logic [63:0] d, input int max_cyc, output bit ok,
                        output logic [63:0] rd, output logic er, output logic rv,
                        output time gt);
    bit exp_g;
    req = 1'b1; we = w; addr = a; strb = s; wdata = d;
    ok = 1'b0; gt = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      #1;
      exp_g = !(is_push(w, a, s) && fifo_cnt_cur == DEPTH);
      n_checks++;
      if (gnt !== exp_g) begin
        n_fails++;
        $display("FAIL gnt a=%h: got %b expected %b", a, gnt, exp_g);
      end
      if (gnt === 1'b1) begin
        ok = 1'b1;
        gt = $time + 7;
        g_cnt = fifo_cnt_cur;
        if (is_push(w, a, s)) q.push_back(d[7:0]);
      end
      step();
    end
    req = 1'b0; we = 1'b0;
    rv = rvalid; rd = rdata; er = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = A_ST; strb = '0; wdata = '0; tx_ready = 1'b0;
    #2;
    n_checks++;
    if ({gnt, rvalid, err, stop, tx_valid} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_flags: got %b expected 00000", {gnt, rvalid, err, stop, tx_valid});
    end
    n_checks++;
    if ({rdata, exit_code, tx_data} !== '0) begin
      n_fails++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", rdata, exit_code, tx_data);
    end
    step(); step();
    req = 1'b0; rst_n = 1'b1; t_rel = $time; fifo_cnt_cur = 0;
  endtask

  task automatic test_stop();
    bit ok; logic [63:0] rd; logic er, rv; time gt;
    do_req(1, A_STOP, 8'hF0, 64'h55, 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({rv, er, stop} !== 3'b100) begin
      n_fails++;
      $display("FAIL stop_nostrb: got rv/err/stop %b expected 100", {rv, er, stop});
    end
    do_req(1, A_STOP, 8'hFF, 64'h2A, 5, ok, rd, er, rv, gt);
    m_stop = 1; m_exit = 32'h2A;
    n_checks++;
    if ({rv, er, rd} !== {2'b10, 64'h0}) begin
      n_fails++;
      $display("FAIL stop_resp: got rv=%b err=%b rdata=%h expected 1 0 0", rv, er, rd);
    end
    n_checks++;
    if ({stop, exit_code} !== {1'b1, 32'h2A}) begin
      n_fails++;
      $display("FAIL stop_latch: got %b %h expected 1 0000002a", stop, exit_code);
    end
    do_req(1, A_STOP, 8'hFF, 64'h7, 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({rv, er, exit_code} !== {2'b10, 32'h2A}) begin
      n_fails++;
      $display("FAIL stop_second: got rv=%b err=%b exit=%h expected 1 0 2a", rv, er, exit_code);
    end
  endtask

  task automatic test_txfifo();
    bit ok; logic [63:0] rd; logic er, rv; time gt;
    ready_mode = 0;
    for (int b = 0; b < 4; b++) begin
      do_req(1, A_TX, 8'h01, 64'h41 + 64'(b), 5, ok, rd, er, rv, gt);
      n_checks++;
      if ({ok, rv, er} !== 3'b110) begin
        n_fails++;
        $display("FAIL tx_push%0d: got ok/rv/err %b expected 110", b, {ok, rv, er});
      end
    end
    do_req(1, A_TX, 8'h01, 64'h45, 3, ok, rd, er, rv, gt);
    n_checks++;
    if ({ok, rv} !== 2'b00) begin
      n_fails++;
      $display("FAIL tx_full_hold: got ok/rv %b expected 00", {ok, rv});
    end
    do_req(0, A_ST, 8'h00, 64'h0, 5, ok, rd, er, rv, gt);
    n_checks++;
    if (rd !== status_word(g_cnt) || rd[15:8] !== 8'd4 || rd[1] !== 1'b1) begin
      n_fails++;
      $display("FAIL tx_full_status: got %h expected %h", rd, status_word(g_cnt));
    end
    ready_mode = 2;
    do_req(1, A_TX, 8'h01, 64'h45, 3, ok, rd, er, rv, gt);
    n_checks++;
    if ({ok, rv, er} !== 3'b110) begin
      n_fails++;
      $display("FAIL tx_pop_grant: got ok/rv/err %b expected 110", {ok, rv, er});
    end
    do_req(1, A_TX, 8'hFE, 64'h99, 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({ok, rv, er} !== 3'b110) begin
      n_fails++;
      $display("FAIL tx_nostrb: got ok/rv/err %b expected 110", {ok, rv, er});
    end
    ready_mode = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    ready_mode = 0;
    step();
    n_checks++;
    if ({tx_valid, 32'(q.size())} !== 33'b0) begin
      n_fails++;
      $display("FAIL tx_drain: got valid=%b model_left=%0d expected 0 0", tx_valid, q.size());
    end
  endtask

  task automatic test_scratch();
    bit ok; logic [63:0] rd; logic er, rv; time gt;
    do_req(1, A_SC, 8'hFF, 64'h1122334455667788, 5, ok, rd, er, rv, gt);
    do_req(1, A_SC, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 5, ok, rd, er, rv, gt);
    do_req(0, A_SC, 8'h00, 64'h0, 5, ok, rd, er, rv, gt);
    m_scratch = 64'h11223344FFFFFFFF;
    n_checks++;
    if ({rv, er, rd} !== {2'b10, 64'h11223344FFFFFFFF}) begin
      n_fails++;
      $display("FAIL scratch_merge: got rv=%b err=%b rdata=%h expected 1 0 11223344ffffffff", rv, er, rd);
    end
  endtask

  task automatic test_errors();
    bit ok; logic [63:0] rd; logic er, rv; time gt;
    logic [30:0] bad_a [5] = '{31'h100, A_MC, A_ST, A_STOP, 31'h28};
    bit          bad_w [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_req(bad_w[i], bad_a[i], 8'hFF, 64'hDEADBEEFCAFEF00D, 5, ok, rd, er, rv, gt);
      n_checks++;
      if ({rv, er, rd} !== {2'b11, 64'h0}) begin
        n_fails++;
        $display("FAIL err_%0d a=%h: got rv=%b err=%b rdata=%h expected 1 1 0", i, bad_a[i], rv, er, rd);
      end
    end
    do_req(0, A_SC, 8'h00, 64'h0, 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({rd, stop, exit_code} !== {m_scratch, m_stop, m_exit}) begin
      n_fails++;
      $display("FAIL err_nochange: got %h %b %h expected %h %b %h", rd, stop, exit_code, m_scratch, m_stop, m_exit);
    end
  endtask

  task automatic test_mcycle();
    bit ok; logic [63:0] v1, v2; logic er, rv; time g1, g2;
    do_req(0, A_MC, 8'h00, 64'h0, 5, ok, v1, er, rv, g1);
    idle(4);
    do_req(0, A_MC, 8'h00, 64'h0, 5, ok, v2, er, rv, g2);
    n_checks++;
    if (v1 !== mcyc_at(g1)) begin
      n_fails++;
      $display("FAIL mcycle_abs: got %0d expected %0d", v1, mcyc_at(g1));
    end
    n_checks++;
    if (v2 - v1 !== 64'd5) begin
      n_fails++;
      $display("FAIL mcycle_delta: got %0d expected 5", v2 - v1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_back_to_back();
    bit ok; logic [63:0] rd; logic er, rv; time g1, g2;
    do_req(1, A_SC, 8'hF0, 64'hA5A5A5A500000000, 5, ok, rd, er, rv, g1);
    m_scratch[63:32] = 32'hA5A5A5A5;
    do_req(0, A_SC, 8'h00, 64'h0, 5, ok, rd, er, rv, g2);
    n_checks++;
    if ({rv, rd, 64'(g2 - g1)} !== {1'b1, m_scratch, 64'd10}) begin
      n_fails++;
      $display("FAIL b2b: got rv=%b rdata=%h gap=%0d expected 1 %h 10", rv, rd, g2 - g1, m_scratch);
    end
    step();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL rvalid_single: got %b expected 0", rvalid);
    end
  endtask

  task automatic test_random();
    bit ok; logic [63:0] rd, d, exp_rd; logic er, rv; time gt;
    logic [30:0] a; logic [7:0] s; bit w; int r, sel; bit acc;
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 7));
      a = (sel < 5) ? 31'(sel * 8) : (sel == 5) ? 31'h28 : (sel == 6) ? 31'h100 : 31'hF8;
      a = a | 31'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      s = 8'($urandom_range(0, 255));
      d = {$urandom, $urandom};
      r = reg_of(a);
      acc = access_ok(w, a);
      do_req(w, a, s, d, 40, ok, rd, er, rv, gt);
      exp_rd = '0;
      if (acc && !w) begin
        if (r == 2) exp_rd = mcyc_at(gt);
        if (r == 3) exp_rd = m_scratch;
        if (r == 4) exp_rd = status_word(g_cnt);
      end
      if (acc && w && r == 0 && s[3:0] != 0 && !m_stop) begin
        m_stop = 1; m_exit = d[31:0];
      end
      if (acc && w && r == 3)
        for (int b = 0; b < 8; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      n_checks++;
      if ({ok, rv, er, rd} !== {2'b11, !acc, exp_rd}) begin
        n_fails++;
        $display("FAIL rand%0d a=%h we=%b: got ok=%b rv=%b err=%b rdata=%h expected 1 1 %b %h",
                 n, a, w, ok, rv, er, rd, !acc, exp_rd);
      end
      n_checks++;
      if ({stop, exit_code} !== {m_stop, m_exit}) begin
        n_fails++;
        $display("FAIL rand%0d_stop: got %b %h expected %b %h", n, stop, exit_code, m_stop, m_exit);
      end
    end
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    ready_mode = 0;
    step();
  endtask

  task automatic test_reset_midstream();
    bit ok; logic [63:0] rd; logic er, rv; time gt;
    for (int b = 0; b < 3; b++) do_req(1, A_TX, 8'h01, 64'h60 + 64'(b), 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({tx_valid, stop} !== 2'b11) begin
      n_fails++;
      $display("FAIL mid_setup: got valid/stop %b expected 11", {tx_valid, stop});
    end
    req = 1'b1; we = 1'b0; addr = A_SC;
    #1;
    rst_n = 1'b0;
    q.delete(); m_stop = 0; m_exit = '0; m_scratch = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({gnt, rvalid, err, stop, tx_valid, rdata, exit_code, tx_data} !== '0) begin
        n_fails++;
        $display("FAIL mid_reset%0d: got gnt=%b rv=%b err=%b stop=%b txv=%b rdata=%h exit=%h txd=%h expected all 0",
                 i, gnt, rvalid, err, stop, tx_valid, rdata, exit_code, tx_data);
      end
      step();
    end
    req = 1'b0; rst_n = 1'b1; t_rel = $time; fifo_cnt_cur = 0;
    step();
    n_checks++;
    if (rvalid !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_noresp: got rvalid %b expected 0", rvalid);
    end
    do_req(0, A_ST, 8'h00, 64'h0, 5, ok, rd, er, rv, gt);
    n_checks++;
    if ({rv, er, rd} !== {2'b10, 64'h4}) begin
      n_fails++;
      $display("FAIL mid_status: got rv=%b err=%b rdata=%h expected 1 0 4", rv, er, rd);
    end
    do_req(0, A_MC, 8'h00, 64'h0, 5, ok, rd, er, rv, gt);
    n_checks++;
    if (rd !== mcyc_at(gt)) begin
      n_fails++;
      $display("FAIL mid_mcycle: got %0d expected %0d", rd, mcyc_at(gt));
    end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_txfifo();
    test_scratch();
    test_errors();
    test_mcycle();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/tiny_soc_mmio_responder.md
TINY_SOC_MMIO_RESPONDER -- requirements
Module: tiny_soc_mmio_responder

Interface
REQ-001 SHALL have parameter MMIOAddrWidth, default 31, MMIO byte-address width.
REQ-002 SHALL have parameter DataWidth, default 64, data bus width; only 64 is supported.
REQ-003 SHALL have parameter StrbWidth, default DataWidth/8, byte-strobe width.
REQ-004 SHALL have parameter TxDepth, default 4, TX FIFO depth in entries; must be a power of 2, at least 2.
REQ-005 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-007 mmio_req_i  input  1  request valid from the core memory top.
REQ-008 mmio_we_i  input  1  1 = write, 0 = read.
REQ-009 mmio_addr_i  input  MMIOAddrWidth  byte address; bits [2:0] are ignored.
REQ-010 mmio_strb_i  input  StrbWidth  write byte enables.
REQ-011 mmio_wdata_i  input  DataWidth  write data.
REQ-012 mmio_gnt_o  output  1  request accepted this cycle.
REQ-013 mmio_rvalid_o  output  1  response valid, one pulse per granted request.
REQ-014 mmio_rdata_o  output  DataWidth  read data; zero for writes and errors.
REQ-015 mmio_err_o  output  1  response error flag, qualified by rvalid.
REQ-016 stop_o  output  1  sticky simulation-stop flag.
REQ-017 exit_code_o  output  32  exit code latched with stop.
REQ-018 tx_valid_o  output  1  TX byte available; head of the TX FIFO.
REQ-019 tx_data_o  output  8  TX byte.
REQ-020 tx_ready_i  input  1  TX sink accepts the byte when tx_valid_o and tx_ready_i are both 1.

Function
REQ-021 Register map, offset = addr[7:3]*8, decoded only when addr[MMIOAddrWidth-1:8]==0: 0x00 STOP (W), 0x08 TXDATA (W), 0x10 MCYCLE (R), 0x18 SCRATCH (R/W), 0x20 STATUS (R); every other address is unmapped.
REQ-022 Grant: mmio_gnt_o = mmio_req_i, except it SHALL be 0 for a TXDATA write with strb[0]=1 while the FIFO is full.
REQ-023 Requester rule: the requester holds req, we, addr, strb and wdata stable until it sees gnt.
REQ-024 Response: exactly one mmio_rvalid_o pulse in the cycle after each grant; back-to-back grants give back-to-back responses; no internal queueing.
REQ-025 Error: an unmapped address, a read of a W-only register, or a write to an R-only register SHALL give err=1 and rdata=0, with no state change.
REQ-026 STOP write: stop_o<=1 and exit_code_o<=wdata[31:0], only if strb[3:0] is nonzero and stop_o is currently 0; later STOP writes are ignored but still respond with err=0.
REQ-027 TXDATA write with strb[0]=1: push wdata[7:0]; with strb[0]=0: no push, err=0.
REQ-028 FIFO: a simultaneous push and pop in the same cycle is legal, including when full (gnt is still withheld when full) and when empty (the pushed byte becomes visible in the next cycle).
REQ-029 FIFO: the count is a log2(TxDepth)+1-bit value; pointers wrap modulo TxDepth.
REQ-030 FIFO: tx_data_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0.
REQ-031 MCYCLE: 64-bit free-running counter, increments every cycle, wraps at 2^64-1 to 0.
REQ-032 MCYCLE read: returns the counter value sampled in the grant cycle.
REQ-033 SCRATCH: 64-bit; a write updates only the bytes whose strb bit is 1; a read returns the current value.
REQ-034 STATUS read: rdata[0]=stop_o, rdata[1]=FIFO full, rdata[2]=FIFO empty, rdata[15:8]=FIFO count; all other bits 0.
REQ-035 Read responses: mmio_rdata_o SHALL be registered; the value captured at the grant is presented with rvalid.

Reset
REQ-036 On rst_ni=0, immediately: gnt=0 (combinational, masked by reset), rvalid=0, rdata=0, err=0, stop_o=0, exit_code_o=0, tx_valid_o=0, tx_data_o=0, FIFO empty, MCYCLE=0, SCRATCH=0.
REQ-037 A request granted in the cycle reset asserts SHALL produce no response.
REQ-038 Bytes in the TX FIFO at reset are discarded.
REQ-039 First MCYCLE increment occurs on the first rising edge after rst_ni deasserts.

Verification
REQ-040 Write STOP, wdata=0x0000_0000_0000_002A, strb=0xFF -> next cycle rvalid=1, err=0; stop_o=1, exit_code_o=0x2A; a second STOP with 0x7 leaves exit_code_o=0x2A.
REQ-041 With tx_ready_i=0, write TXDATA with bytes 0x41..0x45 -> four grants; the fifth request is held with gnt=0 and STATUS shows count=4, full=1; one tx_ready_i pulse pops 0x41 and grants 0x45 in the same or next cycle.
REQ-042 Write SCRATCH=0x1122334455667788 with strb=0xFF, then write 0xFFFF... with strb=0x0F, then read -> rdata=0x11223344FFFFFFFF.
REQ-043 Read at 0x100 and write at 0x10 -> err=1, rdata=0 each; no state change.
REQ-044 Two MCYCLE reads granted 5 cycles apart -> values differ by exactly 5.
REQ-045 Assert rst_ni=0 mid-stream with 3 bytes queued and stop_o=1 -> all outputs are 0 while reset is held; after release STATUS reads empty=1, count=0.
